// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional checksum support is enabled by defining IMEM_LOADER_CHKSUM_EN.
package imem_loader_pkg;

  localparam int CNT_W = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam int DEPTH_DEF = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_PAYLOAD,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs four little-endian bytes into a 32-bit word.
// word_valid pulses for one cycle after the fourth byte is taken.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             accept,
  input  logic [7:0]       data,
  output logic [IDX_W-1:0] byte_idx,
  output logic [31:0]      word,
  output logic             word_valid
);

  logic [23:0] lanes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx   <= '0;
      lanes      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_idx <= '0;
        lanes    <= '0;
      end else if (accept) begin
        byte_idx <= byte_idx + IDX_W'(1);
        unique case (byte_idx)
          2'd0: lanes[7:0]   <= data;
          2'd1: lanes[15:8]  <= data;
          2'd2: lanes[23:16] <= data;
          default: begin
            word       <= {data, lanes};
            word_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: fills instruction memory from a host byte stream, then
// releases the CPU. Checksum byte optional via IMEM_LOADER_CHKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              boot_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [DATA_W-1:0] imem_data_o,
  output logic              start_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam logic [ADDR_W:0] ONE = 1;

  state_t            state;
  logic [7:0]        cnt_lo;
  logic [CNT_W-1:0]  n_words;
  logic [CNT_W-1:0]  n_rx;
  logic [ADDR_W:0]   wcnt;
  logic              accept;
  logic              last_word;
  logic [IDX_W-1:0]  byte_idx;
  logic [31:0]       word;
  logic              word_valid;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0]        chk;
`endif

  assign rx_ready_o = (state == S_HDR_LO) || (state == S_HDR_HI) ||
                      (state == S_PAYLOAD) || (state == S_CHECK);
  assign start_o    = (state == S_DONE);
  assign err_o      = (state == S_ERR);
  assign busy_o     = !((state == S_IDLE) || (state == S_DONE) ||
                        (state == S_ERR));

  // A restart wins over a byte arriving in the same cycle.
  assign accept    = rx_valid_i && rx_ready_o && !boot_i;
  assign n_rx      = {rx_data_i, cnt_lo};
  assign last_word = (CNT_W'(wcnt) + CNT_W'(1)) == n_words;

  assign imem_we_o   = word_valid;
  assign imem_data_o = DATA_W'(word);

  byte_packer u_packer (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .clear      (boot_i),
    .accept     (accept && (state == S_PAYLOAD)),
    .data       (rx_data_i),
    .byte_idx   (byte_idx),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= S_IDLE;
      cnt_lo      <= '0;
      n_words     <= '0;
      wcnt        <= '0;
      imem_addr_o <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
      chk         <= '0;
`endif
    end else if (boot_i) begin
      state       <= S_HDR_LO;
      cnt_lo      <= '0;
      n_words     <= '0;
      wcnt        <= '0;
      imem_addr_o <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
      chk         <= '0;
`endif
    end else if (accept) begin
      unique case (state)
        S_HDR_LO: begin
          cnt_lo <= rx_data_i;
          state  <= S_HDR_HI;
        end
        S_HDR_HI: begin
          n_words <= n_rx;
          wcnt    <= '0;
          if (n_rx == '0 || n_rx > CNT_W'(DEPTH)) state <= S_ERR;
          else state <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
`ifdef IMEM_LOADER_CHKSUM_EN
          chk <= chk ^ rx_data_i;
`endif
          if (byte_idx == IDX_W'(BYTES_PER_WORD - 1)) begin
            imem_addr_o <= wcnt[ADDR_W-1:0];
            wcnt        <= wcnt + ONE;
            if (last_word) begin
`ifdef IMEM_LOADER_CHKSUM_EN
              state <= S_CHECK;
`else
              state <= S_DONE;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHKSUM_EN
        S_CHECK: state <= (rx_data_i == chk) ? S_DONE : S_ERR;
`endif
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a frame-level write model.
// Checksum scenarios are included when IMEM_LOADER_CHKSUM_EN is defined.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        boot = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] data;
  logic        start;
  logic        err;
  logic        busy;

  imem_loader dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .boot_i      (boot),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .imem_we_o   (we),
    .imem_addr_o (addr),
    .imem_data_o (data),
    .start_o     (start),
    .err_o       (err),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int due_cyc = -10;
  logic        exp_we;

  logic [31:0] exp_d[$];
  logic [7:0]  exp_a[$];
  logic [31:0] log_d[$];
  logic [7:0]  log_a[$];
  logic [7:0]  pay[0:1023];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every write must land exactly one cycle after a word's 4th byte,
  // and carry the next address/word the frame model predicts.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_we = (cyc == due_cyc);
      if (exp_we || we) begin
        check("we_timing", we, exp_we);
        if (we) begin
          log_a.push_back(addr);
          log_d.push_back(data);
          if (exp_d.size() > 0) begin
            check("waddr", addr, exp_a.pop_front());
            check("wdata", data, exp_d.pop_front());
          end else begin
            check("unexpected_write", we, 1'b0);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit last4, input int gmax);
    bit ok;
    int t;
    ok = 0;
    t = 0;
    if (gmax > 0) begin
      int g;
      g = $urandom_range(gmax, 0);
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
    end
    rx_data = b;
    rx_valid = 1'b1;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        ok = 1;
      end
      t++;
    end
    #1;
    rx_valid = 1'b0;
    if (!ok) check("rx_timeout", rx_ready, 1'b1);
    if (ok && last4) due_cyc = cyc;
  endtask

  task automatic boot_pulse();
    boot = 1'b1;
    @(posedge clk);
    #1;
    boot = 1'b0;
  endtask

  task automatic send_hdr(input int n);
    logic [15:0] v;
    v = 16'(n);
    send_byte(v[7:0], 0, 0);
    send_byte(v[15:8], 0, 0);
  endtask

  task automatic send_payload(input int nbytes, input int gmax);
    for (int i = 0; i < nbytes; i++) begin
      if (i % 4 == 0 && i + 3 < nbytes) begin
        exp_a.push_back(8'(i / 4));
        exp_d.push_back({pay[i+3], pay[i+2], pay[i+1], pay[i]});
      end
      send_byte(pay[i], (i % 4) == 3, gmax);
    end
  endtask

  task automatic send_chk(input int nbytes, input logic [7:0] flip);
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < nbytes; i++) x ^= pay[i];
    send_byte(x ^ flip, 0, 0);
`endif
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic load_basic();
    pay[0] = 8'h13; pay[1] = 8'h00; pay[2] = 8'h08; pay[3] = 8'h20;
    pay[4] = 8'h14; pay[5] = 8'h00; pay[6] = 8'h09; pay[7] = 8'h20;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_outs", {rx_ready, we, addr, data, start, err, busy}, 64'h0);
    #20 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_ready", rx_ready, 1'b0);
    check("idle_busy", busy, 1'b0);

    // Basic two-word load
    load_basic();
    boot_pulse();
    check("hdr_busy", busy, 1'b1);
    send_hdr(2);
    send_payload(8, 0);
`ifdef IMEM_LOADER_CHKSUM_EN
    check("pre_chk_start", start, 1'b0);
    send_chk(8, 8'h00);
`endif
    @(negedge clk);
    check("basic_start", start, 1'b1);
    check("basic_busy", busy, 1'b0);
    check("basic_ready", rx_ready, 1'b0);
    settle();
    check("basic_nwr", log_a.size(), 2);
    check("basic_a0", log_a[0], 8'h00);
    check("basic_d0", log_d[0], 32'h20080013);
    check("basic_a1", log_a[1], 8'h01);
    check("basic_d1", log_d[1], 32'h20090014);

    // Bad counts
    log_a.delete(); log_d.delete();
    boot_pulse();
    check("boot_drops_start", start, 1'b0);
    send_hdr(0);
    @(negedge clk);
    check("n0_err", err, 1'b1);
    check("n0_start", start, 1'b0);
    check("n0_busy", busy, 1'b0);
    check("n0_ready", rx_ready, 1'b0);
    boot_pulse();
    check("boot_drops_err", err, 1'b0);
    send_hdr(257);
    @(negedge clk);
    check("n257_err", err, 1'b1);
    settle();
    check("bad_nwr", log_a.size(), 0);

`ifdef IMEM_LOADER_CHKSUM_EN
    // Corrupted checksum: words written but CPU not started
    load_basic();
    boot_pulse();
    send_hdr(2);
    send_payload(8, 0);
    send_chk(8, 8'h01);
    @(negedge clk);
    check("chk_bad_err", err, 1'b1);
    check("chk_bad_start", start, 1'b0);
    settle();
    check("chk_bad_nwr", log_a.size(), 2);
    log_a.delete(); log_d.delete();
`endif

    // Full-depth load, gap-free then with random gaps
    for (int i = 0; i < 1024; i++) pay[i] = 8'($urandom);
    for (int pass = 0; pass < 2; pass++) begin
      log_a.delete(); log_d.delete();
      boot_pulse();
      send_hdr(256);
      send_payload(1024, pass * 5);
      send_chk(1024, 8'h00);
      @(negedge clk);
      check("full_start", start, 1'b1);
      settle();
      check("full_nwr", log_a.size(), 256);
      check("full_last_addr", log_a[255], 8'hff);
    end

    // Restart after 6 of 8 payload bytes
    load_basic();
    log_a.delete(); log_d.delete();
    boot_pulse();
    send_hdr(2);
    send_payload(6, 0);
    boot_pulse();
    check("restart_busy", busy, 1'b1);
    settle();
    check("restart_nwr", log_a.size(), 1);
    pay[0] = 8'hef; pay[1] = 8'hbe; pay[2] = 8'had; pay[3] = 8'hde;
    send_hdr(1);
    send_payload(4, 0);
    send_chk(4, 8'h00);
    @(negedge clk);
    check("restart_start", start, 1'b1);
    settle();
    check("restart_nwr2", log_a.size(), 2);
    check("restart_a", log_a[1], 8'h00);
    check("restart_d", log_d[1], 32'hdeadbeef);

    // Asynchronous reset in the middle of a payload
    load_basic();
    boot_pulse();
    send_hdr(2);
    send_payload(3, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_outs", {rx_ready, we, addr, data, start, err, busy}, 64'h0);
    exp_a.delete(); exp_d.delete();
    due_cyc = -10;
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b1;
    settle();
    check("post_rst_ready", rx_ready, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_start", start, 1'b0);
    log_a.delete(); log_d.delete();
    boot_pulse();
    send_hdr(1);
    send_payload(4, 0);
    send_chk(4, 8'h00);
    @(negedge clk);
    check("recover_start", start, 1'b1);
    settle();
    check("recover_d", log_d[0], 32'h20080013);
    check("missed_writes", exp_d.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
